debug_slave_sysclk_ctrl: RTL and testbench



---
 rtl/debug_slave_sysclk_ctrl.sv | 163 ++++++++++++++++
 tb/tb_debug_slave_sysclk_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_slave_sysclk_ctrl.sv
// debug_slave_sysclk_ctrl
// System-clock half of the JTAG debug slave. Brings the TCK-domain update
// strobes across with per-strobe synchronisers, edge-detects them, captures
// the shift-register word and issues one-hot action / no-action pulses per IR
// code. A command then stays pending until the CPU debug module acknowledges
// it; update strobes that land while a command is pending are counted as
// overruns.
//
// Command handshake: pending acts as "valid" and action_ack as "ready". A
// command is consumed on any clock edge where both are high. action_ack while
// pending is low has no effect. A new command is accepted on an update event
// when pending is low or when the current command is consumed on the same
// edge; otherwise the event is dropped and counted.
//
// SYNC_STAGES must be in 2..4 and ACT_BIT must be below DR_WIDTH.

module debug_slave_sysclk_ctrl #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 35,
  parameter int OVF_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic                     action_ack,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [IR_WIDTH-1:0]      ir_q,
  output logic [2**IR_WIDTH-1:0]   take_action,
  output logic [2**IR_WIDTH-1:0]   take_no_action,
  output logic                     pending,
  output logic                     uir_seen,
  output logic [OVF_WIDTH-1:0]     overrun_cnt
);

  localparam int NUM_CH = 2**IR_WIDTH;

  // Events are masked for SYNC_STAGES+1 cycles after reset release so that a
  // strobe held high through reset never looks like a fresh rising edge.
  localparam logic [2:0] BLANK_INIT = 3'(SYNC_STAGES + 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Registered state
  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0]  uir_sync_q, uir_sync_d;
  logic                    udr_dly_q, udr_dly_d;
  logic                    uir_dly_q, uir_dly_d;
  logic [2:0]              blank_q, blank_d;
  logic [DR_WIDTH-1:0]     jdo_q, jdo_d;
  logic [IR_WIDTH-1:0]     ir_d;
  logic [NUM_CH-1:0]       take_action_q, take_action_d;
  logic [NUM_CH-1:0]       take_no_action_q, take_no_action_d;
  logic                    pending_q, pending_d;
  logic                    uir_seen_q, uir_seen_d;
  logic [OVF_WIDTH-1:0]    overrun_cnt_q, overrun_cnt_d;

  // Combinational helpers
  logic                    blanked;
  logic                    udr_event;
  logic                    uir_event;
  logic                    accept;
  logic [NUM_CH-1:0]       ch_onehot;

  // Synchroniser shifting, blanking countdown and rising-edge detection
  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_dly_d  = udr_sync_q[SYNC_STAGES-1];
    uir_dly_d  = uir_sync_q[SYNC_STAGES-1];
    blanked    = (blank_q != 3'd0);
    blank_d    = blanked ? (blank_q - 3'd1) : 3'd0;
    udr_event  = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q & ~blanked;
    uir_event  = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q & ~blanked;
  end

  // Command FSM next-state: capture, pulse generation, ack and overrun count
  always_comb begin
    state_d          = state_q;
    jdo_d            = jdo_q;
    ir_d             = ir_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    pending_d        = pending_q;
    overrun_cnt_d    = overrun_cnt_q;
    uir_seen_d       = uir_event;
    ch_onehot        = '0;
    ch_onehot[ir_in] = 1'b1;
    // A pending command that is acknowledged this edge frees the slot for
    // an event arriving on the very same edge.
    accept           = udr_event & ((state_q == ST_IDLE) | action_ack);

    if (accept) begin
      jdo_d     = sr;
      ir_d      = ir_in;
      pending_d = 1'b1;
      state_d   = ST_PENDING;
      if (sr[ACT_BIT]) begin
        take_action_d = ch_onehot;
      end else begin
        take_no_action_d = ch_onehot;
      end
    end else if (state_q == ST_PENDING) begin
      if (action_ack) begin
        pending_d = 1'b0;
        state_d   = ST_IDLE;
      end else if (udr_event) begin
        if (!(&overrun_cnt_q)) begin
          overrun_cnt_d = overrun_cnt_q + OVF_WIDTH'(1);
        end
      end
    end
  end

  // All state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      udr_sync_q       <= '0;
      uir_sync_q       <= '0;
      udr_dly_q        <= 1'b0;
      uir_dly_q        <= 1'b0;
      blank_q          <= BLANK_INIT;
      jdo_q            <= '0;
      ir_q             <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      pending_q        <= 1'b0;
      uir_seen_q       <= 1'b0;
      overrun_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      udr_dly_q        <= udr_dly_d;
      uir_dly_q        <= uir_dly_d;
      blank_q          <= blank_d;
      jdo_q            <= jdo_d;
      ir_q             <= ir_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      pending_q        <= pending_d;
      uir_seen_q       <= uir_seen_d;
      overrun_cnt_q    <= overrun_cnt_d;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign pending        = pending_q;
  assign uir_seen       = uir_seen_q;
  assign overrun_cnt    = overrun_cnt_q;

endmodule

// File: tb/tb_debug_slave_sysclk_ctrl.sv
// Bench for debug_slave_sysclk_ctrl. Two instances share one stimulus
// stream: u_a with a 2-stage synchroniser and u_b with a 3-stage one. A
// history-based model predicts every output of both each cycle.

module tb_debug_slave_sysclk_ctrl;

  localparam int IRW  = 2;
  localparam int DRW  = 38;
  localparam int ACTB = 35;
  localparam int OVW  = 4;
  localparam int S_A  = 2;
  localparam int S_B  = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IRW-1:0]  ir_in;
  logic [DRW-1:0]  sr;
  logic            vs_udr, vs_uir, action_ack;

  logic [DRW-1:0]  jdo_a, jdo_b;
  logic [IRW-1:0]  irq_a, irq_b;
  logic [3:0]      ta_a, ta_b, tna_a, tna_b;
  logic            pend_a, pend_b, uir_a, uir_b;
  logic [OVW-1:0]  ovf_a, ovf_b;

  debug_slave_sysclk_ctrl #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .SYNC_STAGES(S_A), .ACT_BIT(ACTB), .OVF_WIDTH(OVW)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .action_ack(action_ack),
    .jdo(jdo_a), .ir_q(irq_a), .take_action(ta_a), .take_no_action(tna_a),
    .pending(pend_a), .uir_seen(uir_a), .overrun_cnt(ovf_a)
  );

  debug_slave_sysclk_ctrl #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .SYNC_STAGES(S_B), .ACT_BIT(ACTB), .OVF_WIDTH(OVW)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .action_ack(action_ack),
    .jdo(jdo_b), .ir_q(irq_b), .take_action(ta_b), .take_no_action(tna_b),
    .pending(pend_b), .uir_seen(uir_b), .overrun_cnt(ovf_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The strobes are recorded as they are sampled each edge (forced to 0 on
  // reset edges). A rising edge of a strobe seen S edges ago becomes an event
  // now, unless the last reset edge is within S+1 edges.
  logic udr_h[$];
  logic uir_h[$];
  int   edge_n   = 0;
  int   last_rst = 0;

  logic [DRW-1:0] m_jdo[2];
  logic [IRW-1:0] m_ir[2];
  logic [3:0]     m_ta[2];
  logic [3:0]     m_tna[2];
  logic           m_pend[2];
  logic           m_uir[2];
  logic [OVW-1:0] m_ovf[2];

  function automatic logic hbit(input bit is_uir, input int idx);
    if (idx < 0) return 1'b0;
    return is_uir ? uir_h[idx] : udr_h[idx];
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_jdo[i] = '0; m_ir[i] = '0; m_ta[i] = '0; m_tna[i] = '0;
      m_pend[i] = 1'b0; m_uir[i] = 1'b0; m_ovf[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  s;
      bit  ev_d, ev_i, open;
      s = (i == 0) ? S_A : S_B;
      if (!reset_n) begin
        m_jdo[i] = '0; m_ir[i] = '0; m_ta[i] = '0; m_tna[i] = '0;
        m_pend[i] = 1'b0; m_uir[i] = 1'b0; m_ovf[i] = '0;
      end else begin
        open = (edge_n - last_rst) > (s + 1);
        ev_d = open && hbit(1'b0, edge_n - s) && !hbit(1'b0, edge_n - s - 1);
        ev_i = open && hbit(1'b1, edge_n - s) && !hbit(1'b1, edge_n - s - 1);
        m_uir[i] = ev_i;
        m_ta[i]  = '0;
        m_tna[i] = '0;
        if (ev_d && (!m_pend[i] || action_ack)) begin
          m_jdo[i]  = sr;
          m_ir[i]   = ir_in;
          m_pend[i] = 1'b1;
          if (sr[ACTB]) m_ta[i] = 4'(1 << ir_in);
          else          m_tna[i] = 4'(1 << ir_in);
        end else if (m_pend[i]) begin
          if (action_ack) m_pend[i] = 1'b0;
          else if (ev_d && m_ovf[i] != 4'hF) m_ovf[i] = m_ovf[i] + 4'd1;
        end
      end
    end
    if (!reset_n) last_rst = edge_n;
    udr_h.push_back(reset_n & vs_udr);
    uir_h.push_back(reset_n & vs_uir);
    edge_n++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("a.jdo",  64'(jdo_a),  64'(m_jdo[0]));
      check("a.ir_q", 64'(irq_a),  64'(m_ir[0]));
      check("a.ta",   64'(ta_a),   64'(m_ta[0]));
      check("a.tna",  64'(tna_a),  64'(m_tna[0]));
      check("a.pend", 64'(pend_a), 64'(m_pend[0]));
      check("a.uir",  64'(uir_a),  64'(m_uir[0]));
      check("a.ovf",  64'(ovf_a),  64'(m_ovf[0]));
      check("b.jdo",  64'(jdo_b),  64'(m_jdo[1]));
      check("b.ir_q", 64'(irq_b),  64'(m_ir[1]));
      check("b.ta",   64'(ta_b),   64'(m_ta[1]));
      check("b.tna",  64'(tna_b),  64'(m_tna[1]));
      check("b.pend", 64'(pend_b), 64'(m_pend[1]));
      check("b.uir",  64'(uir_b),  64'(m_uir[1]));
      check("b.ovf",  64'(ovf_b),  64'(m_ovf[1]));
    end
  end

  // Literal expectation applied to both the DUT and the model
  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] mdl,
                     input logic [63:0] exp);
    check(name, got, exp);
    check({"model.", name}, mdl, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic udr_start(input logic [IRW-1:0] ir, input logic [DRW-1:0] d);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
  endtask

  task automatic ack_pulse();
    action_ack = 1'b1;
    cyc(1);
    action_ack = 1'b0;
  endtask

  bit udr_done = 1'b0;

  task automatic rand_udr_driver();
    logic [63:0] r;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        cyc($urandom_range(1, 2));
        reset_n = 1'b1;
      end
      r = {$urandom, $urandom};
      udr_start(IRW'($urandom_range(0, 3)), r[DRW-1:0]);
      cyc($urandom_range(4, 7));
      vs_udr = 1'b0;
      cyc($urandom_range(4, 8));
    end
    udr_done = 1'b1;
  endtask

  task automatic rand_uir_driver();
    for (int t = 0; t < 400 && !udr_done; t++) begin
      vs_uir = 1'b1;
      cyc($urandom_range(4, 6));
      vs_uir = 1'b0;
      cyc($urandom_range(4, 20));
    end
  endtask

  task automatic rand_ack_driver();
    for (int t = 0; t < 3000 && !udr_done; t++) begin
      action_ack = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    action_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    vs_udr     = 1'b1;   // held high through reset and beyond
    vs_uir     = 1'b0;
    action_ack = 1'b0;
    ir_in      = '0;
    sr         = '0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc(4);
    reset_n = 1'b1;
    cyc(10);
    lit("rst.a.jdo",  64'(jdo_a),  64'(m_jdo[0]),  64'h0);
    lit("rst.b.jdo",  64'(jdo_b),  64'(m_jdo[1]),  64'h0);
    lit("rst.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h0);
    lit("rst.b.pend", 64'(pend_b), 64'(m_pend[1]), 64'h0);
    vs_udr = 1'b0;
    cyc(6);

    // Action path, IR=2
    udr_start(2'd2, 38'h08_0000_1234);
    cyc(3);
    lit("act.a.ta",   64'(ta_a),   64'(m_ta[0]),   64'h4);
    lit("act.a.jdo",  64'(jdo_a),  64'(m_jdo[0]),  64'h08_0000_1234);
    lit("act.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h1);
    lit("act.b.ta_early", 64'(ta_b), 64'(m_ta[1]), 64'h0);
    cyc(1);
    lit("act.b.ta",   64'(ta_b),   64'(m_ta[1]),   64'h4);
    lit("act.a.ta_clr", 64'(ta_a), 64'(m_ta[0]),   64'h0);
    vs_udr = 1'b0;
    ack_pulse();
    lit("ack.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h0);
    lit("ack.b.pend", 64'(pend_b), 64'(m_pend[1]), 64'h0);
    cyc(4);

    // No-action path, IR=1
    udr_start(2'd1, 38'h00_DEAD_BEEF);
    cyc(3);
    lit("noact.a.tna", 64'(tna_a), 64'(m_tna[0]), 64'h2);
    lit("noact.a.ta",  64'(ta_a),  64'(m_ta[0]),  64'h0);
    lit("noact.a.jdo", 64'(jdo_a), 64'(m_jdo[0]), 64'h00_DEAD_BEEF);
    cyc(1);
    vs_udr = 1'b0;
    ack_pulse();
    cyc(4);

    // Overrun: leave a command pending, then 17 more strobes
    udr_start(2'd0, 38'h08_0000_00AA);
    cyc(4);
    vs_udr = 1'b0;
    cyc(4);
    for (int t = 0; t < 17; t++) begin
      udr_start(IRW'(t), 38'(t + 100));
      cyc(4);
      vs_udr = 1'b0;
      cyc(4);
    end
    lit("ovr.a.jdo", 64'(jdo_a), 64'(m_jdo[0]), 64'h08_0000_00AA);
    lit("ovr.a.ovf", 64'(ovf_a), 64'(m_ovf[0]), 64'hF);
    lit("ovr.b.ovf", 64'(ovf_b), 64'(m_ovf[1]), 64'hF);

    // Ack on the event edge of instance a
    udr_start(2'd3, 38'h1);
    cyc(2);
    action_ack = 1'b1;
    cyc(1);
    action_ack = 1'b0;
    lit("sim.a.jdo",  64'(jdo_a),  64'(m_jdo[0]),  64'h1);
    lit("sim.a.tna",  64'(tna_a),  64'(m_tna[0]),  64'h8);
    lit("sim.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h1);
    lit("sim.a.ovf",  64'(ovf_a),  64'(m_ovf[0]),  64'hF);
    cyc(1);
    lit("sim.b.jdo",  64'(jdo_b),  64'(m_jdo[1]),  64'h1);
    lit("sim.b.tna",  64'(tna_b),  64'(m_tna[1]),  64'h8);
    lit("sim.b.pend", 64'(pend_b), 64'(m_pend[1]), 64'h1);
    vs_udr = 1'b0;
    cyc(4);

    // Reset while pending
    reset_n = 1'b0;
    cyc(2);
    lit("rstp.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h0);
    lit("rstp.a.ovf",  64'(ovf_a),  64'(m_ovf[0]),  64'h0);
    lit("rstp.b.ovf",  64'(ovf_b),  64'(m_ovf[1]),  64'h0);
    reset_n = 1'b1;
    cyc(6);

    // uir in IDLE
    vs_uir = 1'b1;
    cyc(3);
    lit("uir.a.seen", 64'(uir_a),  64'(m_uir[0]),  64'h1);
    lit("uir.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h0);
    lit("uir.a.jdo",  64'(jdo_a),  64'(m_jdo[0]),  64'h0);
    cyc(1);
    lit("uir.b.seen", 64'(uir_b),  64'(m_uir[1]),  64'h1);
    lit("uir.a.clr",  64'(uir_a),  64'(m_uir[0]),  64'h0);
    vs_uir = 1'b0;
    cyc(4);

    // uir in PENDING
    udr_start(2'd2, 38'h08_0000_1234);
    cyc(4);
    vs_udr = 1'b0;
    cyc(2);
    vs_uir = 1'b1;
    cyc(3);
    lit("uirp.a.seen", 64'(uir_a),  64'(m_uir[0]),  64'h1);
    lit("uirp.a.pend", 64'(pend_a), 64'(m_pend[0]), 64'h1);
    lit("uirp.a.jdo",  64'(jdo_a),  64'(m_jdo[0]),  64'h08_0000_1234);
    cyc(1);
    lit("uirp.b.seen", 64'(uir_b),  64'(m_uir[1]),  64'h1);
    vs_uir = 1'b0;
    ack_pulse();
    cyc(4);

    // Randomized traffic
    fork
      rand_udr_driver();
      rand_uir_driver();
      rand_ack_driver();
    join
    vs_uir     = 1'b0;
    action_ack = 1'b0;
    cyc(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
